// File: rtl/led_mode_sequencer.sv
// Button front-end for the LED bar controller: synchronise and debounce the raw buttons,
// run the sine / up-down mode FSM with inactivity timeout, and generate the LED update tick.
module led_mode_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_PERIOD     = 6250000,
  parameter int IDLE_TICKS      = 160
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  output logic       o_mode,
  output logic [1:0] o_ud_incr_decr,
  output logic       o_tick,
  output logic [1:0] o_state
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TICK_PERIOD);
  localparam int IW = (IDLE_TICKS < 1) ? 1 : $clog2(IDLE_TICKS + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_PERIOD - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_TICKS);
  localparam bit            IDLE_EN   = (IDLE_TICKS != 0);

  localparam logic [1:0] S_SINE    = 2'b00;
  localparam logic [1:0] S_UD_HOLD = 2'b01;
  localparam logic [1:0] S_UD_INCR = 2'b10;
  localparam logic [1:0] S_UD_DECR = 2'b11;

  localparam int B_MODE = 0;
  localparam int B_UP   = 1;
  localparam int B_DN   = 2;

  logic [2:0]    w_btn_raw;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_deb;
  logic [DW-1:0] r_deb_cnt [3];
  logic          r_mode_prev;
  logic          w_mode_press;
  logic [TW-1:0] r_tick_cnt;
  logic [IW-1:0] r_idle;
  logic          w_timeout;
  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic          r_mode;
  logic [1:0]    r_ud;
  logic [1:0]    r_state_out;

  assign w_btn_raw = {i_btn_down, i_btn_up, i_btn_mode};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // NOTE: the counter array is reset too, so a reset mid-debounce leaves no partial count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_deb       <= '0;
      r_mode_prev <= 1'b0;
      for (int i = 0; i < 3; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_mode_prev <= r_deb[B_MODE];
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_LAST) begin
          r_deb[i]     <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign w_mode_press = r_deb[B_MODE] & ~r_mode_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                    r_tick_cnt <= '0;
    else if (r_tick_cnt == TICK_LAST) r_tick_cnt <= '0;
    else                             r_tick_cnt <= r_tick_cnt + TW'(1);
  end

  assign o_tick    = (r_tick_cnt == TICK_LAST);
  assign w_timeout = IDLE_EN && (r_idle == IDLE_MAX);

  // NOTE: w_next gets a default first so no path through the block infers a latch.
  always_comb begin
    w_next = r_state;
    if (w_mode_press) begin
      w_next = (r_state == S_SINE) ? S_UD_HOLD : S_SINE;
    end else if (r_state != S_SINE) begin
      if (w_timeout)                         w_next = S_SINE;
      else if (r_deb[B_UP] && !r_deb[B_DN])  w_next = S_UD_INCR;
      else if (r_deb[B_DN] && !r_deb[B_UP])  w_next = S_UD_DECR;
      else                                   w_next = S_UD_HOLD;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_SINE;
    else          r_state <= w_next;
  end

  // Idle time only accumulates while sitting untouched in one UD state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idle <= '0;
    end else if ((w_next != r_state) || (r_state == S_SINE) || (|r_deb)) begin
      r_idle <= '0;
    end else if (o_tick && (r_idle != IDLE_MAX)) begin
      r_idle <= r_idle + IW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode      <= 1'b0;
      r_ud        <= 2'b00;
      r_state_out <= S_SINE;
    end else begin
      r_mode      <= (r_state != S_SINE);
      r_ud        <= (r_state == S_UD_INCR) ? 2'b01 :
                     (r_state == S_UD_DECR) ? 2'b10 : 2'b00;
      r_state_out <= r_state;
    end
  end

  assign o_mode         = r_mode;
  assign o_ud_incr_decr = r_ud;
  assign o_state        = r_state_out;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Self-checking bench for led_mode_sequencer: directed scenarios plus random button
// activity, compared every cycle against a behavioural model of the sequencer.
module tb_led_mode_sequencer;

  localparam int D  = 4;
  localparam int TP = 10;
  localparam int IT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       o_mode;
  logic [1:0] o_ud_incr_decr;
  logic       o_tick;
  logic [1:0] o_state;

  led_mode_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .TICK_PERIOD    (TP),
    .IDLE_TICKS     (IT)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_btn_mode    (btn_mode),
    .i_btn_up      (btn_up),
    .i_btn_down    (btn_down),
    .o_mode        (o_mode),
    .o_ud_incr_decr(o_ud_incr_decr),
    .o_tick        (o_tick),
    .o_state       (o_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_SINE = 0, M_HOLD = 1, M_INCR = 2, M_DECR = 3} mstate_t;

  bit [2:0] m_s1, m_s2, m_deb;   // bit 0 mode, 1 up, 2 down
  int       m_run [3];           // consecutive cycles synced level disagrees with debounced
  bit       m_mode_prev;
  int       m_cyc;               // clock edges since reset release
  mstate_t  m_st;
  int       m_idle;
  bit       e_mode;
  bit [1:0] e_ud;
  bit [1:0] e_state;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_mode_prev = 1'b0;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    m_cyc = 0; m_st = M_SINE; m_idle = 0;
    e_mode = 1'b0; e_ud = 2'b00; e_state = 2'b00;
  endtask

  task automatic model_step(input bit [2:0] raw);
    bit      press;
    bit      tick;
    bit      up, dn;
    mstate_t nxt;
    press = m_deb[0] && !m_mode_prev;
    tick  = (m_cyc % TP) == TP - 1;
    up    = m_deb[1];
    dn    = m_deb[2];
    if (press)                  nxt = (m_st == M_SINE) ? M_HOLD : M_SINE;
    else if (m_st == M_SINE)    nxt = M_SINE;
    else if (IT != 0 && m_idle == IT) nxt = M_SINE;
    else if (up && !dn)         nxt = M_INCR;
    else if (dn && !up)         nxt = M_DECR;
    else                        nxt = M_HOLD;
    if (nxt != m_st || m_st == M_SINE || m_deb != 3'b000) m_idle = 0;
    else if (tick && m_idle < IT) m_idle = m_idle + 1;
    e_mode  = (m_st != M_SINE);
    e_ud    = (m_st == M_INCR) ? 2'b01 : (m_st == M_DECR) ? 2'b10 : 2'b00;
    e_state = 2'(int'(m_st));
    m_st = nxt;
    m_mode_prev = m_deb[0];
    for (int i = 0; i < 3; i++) begin
      if (m_s2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_deb[i] = ~m_deb[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
    m_cyc++;
  endtask

  task automatic compare_all();
    check("o_mode",    o_mode,         e_mode);
    check("o_ud",      o_ud_incr_decr, e_ud);
    check("o_state",   o_state,        e_state);
    check("o_tick",    o_tick,         ((m_cyc % TP) == TP - 1));
    check("ud_not_11", (o_ud_incr_decr == 2'b11), 1'b0);
  endtask

  // One clock cycle: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_step({btn_down, btn_up, btn_mode});
    @(negedge clk);
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_mode(input string name, input bit val, input int budget, output int n);
    n = 0;
    while (o_mode !== val && n < budget) begin
      step();
      n++;
    end
    check(name, o_mode, val);
  endtask

  task automatic wait_ud(input string name, input bit [1:0] val, input int budget, output int n);
    n = 0;
    while (o_ud_incr_decr !== val && n < budget) begin
      step();
      n++;
    end
    check(name, o_ud_incr_decr, val);
  endtask

  // Asserted mid-cycle; outputs must clear before the next clock edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mode",  o_mode,         1'b0);
    check("rst_ud",    o_ud_incr_decr, 2'b00);
    check("rst_state", o_state,        2'b00);
    check("rst_tick",  o_tick,         1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int n;
  int tick_at [$];

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("init_mode", o_mode, 1'b0);
    check("init_ud",   o_ud_incr_decr, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: idle after reset, tick cadence
    for (int k = 1; k <= 30; k++) begin
      step();
      if (o_tick === 1'b1) tick_at.push_back(k);
    end
    check("tick_count", tick_at.size(), 3);
    for (int i = 0; i < tick_at.size() && i < 3; i++) check("tick_cycle", tick_at[i], 9 + 10 * i);

    // 2: mode press latency, then press again back to sine
    btn_mode = 1'b1;
    wait_mode("mode_rise", 1'b1, 30, n);
    check("mode_latency", n, 8);
    steps(20 - n);
    btn_mode = 1'b0;
    steps(10);
    btn_mode = 1'b1;
    wait_mode("mode_fall", 1'b0, 30, n);
    check("mode_fall_latency", n, 8);
    steps(12);
    btn_mode = 1'b0;
    steps(10);

    // 3: up, down, both in UD
    btn_mode = 1'b1;
    wait_mode("enter_ud", 1'b1, 30, n);
    btn_mode = 1'b0;
    btn_up = 1'b1;
    wait_ud("up_incr", 2'b01, 30, n);
    check("up_latency", n, 8);
    steps(30 - n);
    btn_up = 1'b0;
    wait_ud("up_release", 2'b00, 30, n);
    check("up_release_latency", n, 8);
    btn_down = 1'b1;
    wait_ud("down_decr", 2'b10, 30, n);
    check("down_latency", n, 8);
    steps(20);
    btn_up = 1'b1;
    wait_ud("both_hold", 2'b00, 30, n);
    check("both_latency", n, 8);
    check("both_mode", o_mode, 1'b1);
    steps(6);
    btn_up = 1'b0;
    btn_down = 1'b0;
    steps(10);

    // 4: glitches
    btn_up = 1'b1;
    steps(3);
    btn_up = 1'b0;
    steps(12);
    check("up_glitch", o_ud_incr_decr, 2'b00);
    wait_mode("timeout_before_glitch", 1'b0, 80, n);
    btn_mode = 1'b1;
    steps(3);
    btn_mode = 1'b0;
    steps(15);
    check("mode_glitch", o_mode, 1'b0);

    // 5: idle timeout, and restart by an up press
    btn_mode = 1'b1;
    wait_mode("ud_for_timeout", 1'b1, 30, n);
    btn_mode = 1'b0;
    wait_mode("idle_timeout", 1'b0, 80, n);
    btn_mode = 1'b1;
    wait_mode("ud_for_restart", 1'b1, 30, n);
    btn_mode = 1'b0;
    steps(15);
    btn_up = 1'b1;
    steps(6);
    btn_up = 1'b0;
    check("restart_still_ud", o_mode, 1'b1);
    wait_mode("restart_timeout", 1'b0, 80, n);

    // 6: reset mid-debounce, and while incrementing
    btn_mode = 1'b1;
    steps(3);
    do_reset();
    wait_mode("rst_debounce_rise", 1'b1, 30, n);
    check("rst_debounce_latency", n, 8);
    btn_mode = 1'b0;
    btn_up = 1'b1;
    wait_ud("incr_before_rst", 2'b01, 30, n);
    steps(3);
    btn_up = 1'b0;
    btn_mode = 1'b1;
    do_reset();
    wait_mode("rst_incr_rise", 1'b1, 30, n);
    check("rst_incr_latency", n, 8);
    btn_mode = 1'b0;
    steps(10);

    // random button activity with occasional resets
    for (int seg = 0; seg < 300; seg++) begin
      int r;
      r = int'($urandom_range(0, 99));
      btn_mode = (r < 15);
      btn_up   = ($urandom_range(0, 2) == 0);
      btn_down = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) == 0) do_reset();
      steps(int'($urandom_range(1, 12)));
    end
    btn_mode = 1'b0;
    btn_up = 1'b0;
    btn_down = 1'b0;
    steps(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
